add8u_err_monitor: RTL and testbench



---
 rtl/add8u_err_monitor.sv | 194 +++++++++++++++++++
 tb/tb_add8u_err_monitor.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add8u_err_monitor.sv
// Error-statistics monitor for an 8-bit approximate unsigned adder: sample count, error count,
// saturating |error| sum and worst-case error. Define ADD8U_ERRMON_MSE_EN for a squared-error sum.
module add8u_err_monitor #(
  parameter int unsigned N_SAMPLES = 65536,
  parameter int unsigned ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [8:0]       in_o,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sample_cnt,
  output logic [ACC_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [8:0]       wce
`ifdef ADD8U_ERRMON_MSE_EN
  ,
  output logic [ACC_W+17:0] sum_sq_err
`endif
);

`ifdef ADD8U_ERRMON_MSE_EN
  localparam logic [1:0] DrainLast = 2'd2;
`else
  localparam logic [1:0] DrainLast = 2'd1;
`endif
  localparam logic [ACC_W-1:0] NSamp = ACC_W'(N_SAMPLES);
  localparam logic [ACC_W-1:0] NLast = ACC_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] accepted_q, accepted_d;
  logic [1:0]       drain_q, drain_d;
  logic             xfer, stat_clr;

  always_comb begin
    state_d    = state_q;
    accepted_d = accepted_q;
    drain_d    = drain_q;
    stat_clr   = 1'b0;
    in_ready   = (state_q == StRun) && (accepted_q < NSamp);
    xfer       = in_valid && in_ready;
    busy       = (state_q == StRun) || (state_q == StDrain);
    done       = (state_q == StDone);
    if (clear) begin
      state_d    = StIdle;
      accepted_d = '0;
      drain_d    = '0;
      stat_clr   = 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d    = StRun;
            accepted_d = '0;
            stat_clr   = 1'b1;
          end
        end
        StRun: begin
          if (xfer) begin
            accepted_d = accepted_q + ACC_W'(1);
            if (accepted_q == NLast) begin
              state_d = StDrain;
              drain_d = '0;
            end
          end
        end
        StDrain: begin
          // Hold until the last sample has left the pipeline.
          if (drain_q == DrainLast) state_d = StDone;
          else drain_d = drain_q + 2'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      accepted_q <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      accepted_q <= accepted_d;
      drain_q    <= drain_d;
    end
  end

  logic [8:0] exact;
  logic [9:0] diff;
  logic [8:0] abs_c;

  always_comb begin
    exact = {1'b0, in_a} + {1'b0, in_b};
    diff  = {1'b0, in_o} - {1'b0, exact};
    abs_c = 9'(diff[9] ? (10'd0 - diff) : diff);
  end

  logic       s1_valid_q, s1_neq_q;
  logic [8:0] s1_abs_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      s1_valid_q <= 1'b0;
      s1_abs_q   <= '0;
      s1_neq_q   <= 1'b0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_abs_q <= abs_c;
        s1_neq_q <= (diff != 10'd0);
      end
    end
  end

  logic       upd_valid, upd_neq;
  logic [8:0] upd_abs;

`ifdef ADD8U_ERRMON_MSE_EN
  logic        s2_valid_q, s2_neq_q;
  logic [8:0]  s2_abs_q;
  logic [17:0] s2_sq_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      s2_valid_q <= 1'b0;
      s2_abs_q   <= '0;
      s2_neq_q   <= 1'b0;
      s2_sq_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_abs_q   <= s1_abs_q;
      s2_neq_q   <= s1_neq_q;
      s2_sq_q    <= 18'(s1_abs_q) * 18'(s1_abs_q);
    end
  end

  assign upd_valid = s2_valid_q;
  assign upd_abs   = s2_abs_q;
  assign upd_neq   = s2_neq_q;
`else
  assign upd_valid = s1_valid_q;
  assign upd_abs   = s1_abs_q;
  assign upd_neq   = s1_neq_q;
`endif

  logic [ACC_W-1:0] cnt_q, err_q, sum_q;
  logic [8:0]       wce_q;
  logic [ACC_W:0]   sum_ext;

  assign sum_ext = {1'b0, sum_q} + (ACC_W+1)'(upd_abs);

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      cnt_q <= '0;
      err_q <= '0;
      sum_q <= '0;
      wce_q <= '0;
    end else if (upd_valid) begin
      cnt_q <= cnt_q + ACC_W'(1);
      err_q <= err_q + ACC_W'(upd_neq);
      sum_q <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (upd_abs > wce_q) wce_q <= upd_abs;
    end
  end

`ifdef ADD8U_ERRMON_MSE_EN
  logic [ACC_W+17:0] sq_q;
  logic [ACC_W+18:0] sq_ext;

  assign sq_ext = {1'b0, sq_q} + (ACC_W+19)'(s2_sq_q);

  always_ff @(posedge clk) begin
    if (rst || stat_clr) sq_q <= '0;
    else if (upd_valid) sq_q <= sq_ext[ACC_W+18] ? '1 : sq_ext[ACC_W+17:0];
  end

  assign sum_sq_err = sq_q;
`endif

  assign sample_cnt  = cnt_q;
  assign err_cnt     = err_q;
  assign sum_abs_err = sum_q;
  assign wce         = wce_q;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Bench for add8u_err_monitor: cycle model on a 16-sample instance plus directed literal checks on
// 3-sample (10-bit accumulators), 1-sample and exhaustive 65536-sample instances.
module tb_add8u_err_monitor;
  localparam int MainN = 16;
`ifdef ADD8U_ERRMON_MSE_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif
  localparam longint MaxS32 = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int tbl_a [16] = '{5, 200, 255, 0, 255, 10, 100, 1, 128, 7, 50, 0, 33, 200, 99, 12};
  int tbl_b [16] = '{3, 100, 255, 0, 255, 20, 100, 1, 128, 9, 60, 255, 44, 50, 1, 34};
  int tbl_o [16] = '{8, 297, 510, 511, 0, 31, 190, 2, 256, 20, 100, 255, 77, 240, 164, 46};

  // ---------------- main instance (N=16, 32-bit) ----------------
  logic m_rst = 1'b1, m_start = 1'b0, m_clear = 1'b0, m_valid = 1'b0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [8:0] m_o = '0;
  logic m_ready, m_busy, m_done;
  logic [31:0] m_scnt, m_ecnt, m_sum;
  logic [8:0] m_wce;
`ifdef ADD8U_ERRMON_MSE_EN
  logic [49:0] m_sq;
`endif

  add8u_err_monitor #(.N_SAMPLES(MainN), .ACC_W(32)) u_main (
    .clk(clk), .rst(m_rst), .start(m_start), .clear(m_clear), .in_valid(m_valid),
    .in_ready(m_ready), .in_a(m_a), .in_b(m_b), .in_o(m_o), .busy(m_busy), .done(m_done),
    .sample_cnt(m_scnt), .err_cnt(m_ecnt), .sum_abs_err(m_sum), .wce(m_wce)
`ifdef ADD8U_ERRMON_MSE_EN
    , .sum_sq_err(m_sq)
`endif
  );

  // ---------------- 3-sample instance, 10-bit accumulators ----------------
  logic s3_rst = 1'b1, s3_start = 1'b0, s3_valid = 1'b0;
  logic [7:0] s3_a = '0, s3_b = '0;
  logic [8:0] s3_o = '0;
  logic s3_ready, s3_busy, s3_done;
  logic [9:0] s3_scnt, s3_ecnt, s3_sum;
  logic [8:0] s3_wce;
`ifdef ADD8U_ERRMON_MSE_EN
  logic [27:0] s3_sq;
`endif

  add8u_err_monitor #(.N_SAMPLES(3), .ACC_W(10)) u_n3 (
    .clk(clk), .rst(s3_rst), .start(s3_start), .clear(1'b0), .in_valid(s3_valid),
    .in_ready(s3_ready), .in_a(s3_a), .in_b(s3_b), .in_o(s3_o), .busy(s3_busy), .done(s3_done),
    .sample_cnt(s3_scnt), .err_cnt(s3_ecnt), .sum_abs_err(s3_sum), .wce(s3_wce)
`ifdef ADD8U_ERRMON_MSE_EN
    , .sum_sq_err(s3_sq)
`endif
  );

  // ---------------- 1-sample instance ----------------
  logic s1_rst = 1'b1, s1_start = 1'b0, s1_valid = 1'b0;
  logic [7:0] s1_a = '0, s1_b = '0;
  logic [8:0] s1_o = '0;
  logic s1_ready, s1_busy, s1_done;
  logic [31:0] s1_scnt, s1_ecnt, s1_sum;
  logic [8:0] s1_wce;
`ifdef ADD8U_ERRMON_MSE_EN
  logic [49:0] s1_sq;
`endif

  add8u_err_monitor #(.N_SAMPLES(1), .ACC_W(32)) u_n1 (
    .clk(clk), .rst(s1_rst), .start(s1_start), .clear(1'b0), .in_valid(s1_valid),
    .in_ready(s1_ready), .in_a(s1_a), .in_b(s1_b), .in_o(s1_o), .busy(s1_busy), .done(s1_done),
    .sample_cnt(s1_scnt), .err_cnt(s1_ecnt), .sum_abs_err(s1_sum), .wce(s1_wce)
`ifdef ADD8U_ERRMON_MSE_EN
    , .sum_sq_err(s1_sq)
`endif
  );

  // ---------------- exhaustive instance ----------------
  logic bg_rst = 1'b1, bg_start = 1'b0, bg_valid = 1'b0;
  logic [7:0] bg_a = '0, bg_b = '0;
  logic [8:0] bg_o = '0;
  logic bg_ready, bg_busy, bg_done;
  logic [31:0] bg_scnt, bg_ecnt, bg_sum;
  logic [8:0] bg_wce;
`ifdef ADD8U_ERRMON_MSE_EN
  logic [49:0] bg_sq;
`endif

  add8u_err_monitor #(.N_SAMPLES(65536), .ACC_W(32)) u_big (
    .clk(clk), .rst(bg_rst), .start(bg_start), .clear(1'b0), .in_valid(bg_valid),
    .in_ready(bg_ready), .in_a(bg_a), .in_b(bg_b), .in_o(bg_o), .busy(bg_busy), .done(bg_done),
    .sample_cnt(bg_scnt), .err_cnt(bg_ecnt), .sum_abs_err(bg_sum), .wce(bg_wce)
`ifdef ADD8U_ERRMON_MSE_EN
    , .sum_sq_err(bg_sq)
`endif
  );

  // ---------------- behavioural model of the main instance ----------------
  localparam int PIdle = 0, PRun = 1, PDrain = 2, PDone = 3;
  int     ph = PIdle;
  int     acc = 0;
  int     drain_left = 0;
  bit     mdl_on = 1'b0;
  longint e_cnt = 0, e_err = 0, e_sum = 0, e_wce = 0;
  int     q_abs[$];
  int     q_rem[$];

  function automatic int abs_err(input int a, input int b, input int o);
    int e;
    e = o - (a + b);
    return (e < 0) ? -e : e;
  endfunction

  task automatic mdl_zero();
    e_cnt = 0;
    e_err = 0;
    e_sum = 0;
    e_wce = 0;
    q_abs.delete();
    q_rem.delete();
  endtask

  task automatic mdl_apply(input int ab);
    e_cnt++;
    if (ab != 0) e_err++;
    e_sum = (e_sum + ab > MaxS32) ? MaxS32 : e_sum + ab;
    if (ab > e_wce) e_wce = ab;
  endtask

  bit m_rdy_exp, m_xf;

  // Outputs are compared mid-cycle, then the model advances over the coming edge.
  always @(negedge clk) begin
    m_rdy_exp = (ph == PRun) && (acc < MainN);
    if (mdl_on) begin
      chk("in_ready", m_ready, longint'(m_rdy_exp));
      chk("busy", m_busy, longint'(ph == PRun || ph == PDrain));
      chk("done", m_done, longint'(ph == PDone));
      chk("sample_cnt", m_scnt, e_cnt);
      chk("err_cnt", m_ecnt, e_err);
      chk("sum_abs_err", m_sum, e_sum);
      chk("wce", m_wce, e_wce);
    end
    m_xf = m_rdy_exp && m_valid;
    if (m_rst) begin
      mdl_zero();
      ph = PIdle;
      acc = 0;
      drain_left = 0;
      mdl_on = 1'b1;
    end else begin
      for (int i = q_abs.size() - 1; i >= 0; i--) begin
        if (q_rem[i] == 0) begin
          mdl_apply(q_abs[i]);
          q_abs.delete(i);
          q_rem.delete(i);
        end else begin
          q_rem[i] = q_rem[i] - 1;
        end
      end
      if (m_clear) begin
        mdl_zero();
        ph = PIdle;
        acc = 0;
      end else begin
        case (ph)
          PIdle, PDone: begin
            if (m_start) begin
              mdl_zero();
              ph = PRun;
              acc = 0;
            end
          end
          PRun: begin
            if (m_xf) begin
              q_abs.push_back(abs_err(int'(m_a), int'(m_b), int'(m_o)));
              q_rem.push_back(Lat - 2);
              acc++;
              if (acc == MainN) begin
                ph = PDrain;
                drain_left = Lat;
              end
            end
          end
          PDrain: begin
            drain_left--;
            if (drain_left == 0) ph = PDone;
          end
          default: ;
        endcase
      end
    end
  end

  // Feed `count` table vectors into the main instance, optionally with random valid gaps.
  task automatic main_feed(input bit gaps, input int count, input bit poke_start);
    int idx;
    int budget;
    bit v;
    idx = 0;
    budget = 0;
    while (idx < count && budget < 400) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      m_valid = v;
      m_start = poke_start && (budget == 3);
      if (v) begin
        m_a = 8'(tbl_a[idx]);
        m_b = 8'(tbl_b[idx]);
        m_o = 9'(tbl_o[idx]);
      end else begin
        m_a = 8'($urandom);
        m_b = 8'($urandom);
        m_o = 9'($urandom);
      end
      if (v && m_ready) idx++;
      tick();
      budget++;
    end
    m_valid = 1'b0;
    m_start = 1'b0;
    chk("main feed transfers", idx, count);
  endtask

  task automatic main_wait_done(input string name);
    for (int k = 0; k < 20 && !m_done; k++) begin
      m_valid = 1'b1;
      m_a = 8'($urandom);
      m_b = 8'($urandom);
      m_o = 9'($urandom);
      tick();
    end
    m_valid = 1'b0;
    chk(name, m_done, 1);
  endtask

  task automatic main_check_table(input string name);
    chk({name, " sample_cnt"}, m_scnt, 16);
    chk({name, " err_cnt"}, m_ecnt, 9);
    chk({name, " sum_abs_err"}, m_sum, 1123);
    chk({name, " wce"}, m_wce, 511);
`ifdef ADD8U_ERRMON_MSE_EN
    chk({name, " sum_sq_err"}, m_sq, 525643);
`endif
  endtask

  initial begin
    fork
      begin : big_branch
        int idx;
        int budget;
        tick();
        tick();
        bg_rst = 1'b0;
        bg_start = 1'b1;
        tick();
        bg_start = 1'b0;
        idx = 0;
        budget = 0;
        while (idx < 65536 && budget < 66000) begin
          bg_valid = 1'b1;
          bg_a = 8'(idx >> 8);
          bg_b = 8'(idx);
          bg_o = 9'((idx >> 8) + (idx & 255));
          if (bg_ready) idx++;
          tick();
          budget++;
        end
        bg_valid = 1'b0;
        chk("sweep transfers", idx, 65536);
        for (int k = 0; k < 20 && !bg_done; k++) tick();
        chk("sweep done", bg_done, 1);
        chk("sweep busy", bg_busy, 0);
        chk("sweep sample_cnt", bg_scnt, 65536);
        chk("sweep err_cnt", bg_ecnt, 0);
        chk("sweep sum_abs_err", bg_sum, 0);
        chk("sweep wce", bg_wce, 0);
`ifdef ADD8U_ERRMON_MSE_EN
        chk("sweep sum_sq_err", bg_sq, 0);
`endif
      end
      begin : small_branch
        // Main instance: reset, gapped run with an ignored start, clear, reset in DRAIN, rerun.
        tick();
        tick();
        m_rst = 1'b0;
        chk("reset in_ready", m_ready, 0);
        chk("reset done", m_done, 0);
        chk("reset sample_cnt", m_scnt, 0);
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        main_feed(1'b1, 16, 1'b1);
        main_wait_done("runA done");
        main_check_table("runA");

        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        main_feed(1'b1, 5, 1'b0);
        m_clear = 1'b1;
        tick();
        m_clear = 1'b0;
        chk("clear busy", m_busy, 0);
        chk("clear done", m_done, 0);
        chk("clear sample_cnt", m_scnt, 0);
        chk("clear sum_abs_err", m_sum, 0);
        chk("clear wce", m_wce, 0);

        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        main_feed(1'b0, 16, 1'b0);
        chk("drain busy", m_busy, 1);
        chk("drain in_ready", m_ready, 0);
        m_rst = 1'b1;
        tick();
        m_rst = 1'b0;
        chk("rst-drain busy", m_busy, 0);
        chk("rst-drain done", m_done, 0);
        chk("rst-drain sample_cnt", m_scnt, 0);
        chk("rst-drain err_cnt", m_ecnt, 0);
        chk("rst-drain wce", m_wce, 0);

        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        main_feed(1'b1, 16, 1'b0);
        main_wait_done("runD done");
        main_check_table("runD");

        // 3-sample instance: small errors, then saturation of the 10-bit sum.
        s3_rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
          s3_start = 1'b1;
          tick();
          s3_start = 1'b0;
          for (int i = 0; i < 3; i++) begin
            chk("n3 in_ready", s3_ready, 1);
            if (r == 0 && i == 1) chk("n3 latency 1", s3_scnt, 0);
            if (r == 0 && i == 2) chk("n3 latency 2", s3_scnt, (Lat == 2) ? 1 : 0);
            s3_valid = 1'b1;
            s3_a = (r == 0) ? 8'(tbl_a[i]) : 8'd0;
            s3_b = (r == 0) ? 8'(tbl_b[i]) : 8'd0;
            s3_o = (r == 0) ? 9'(tbl_o[i]) : 9'd511;
            tick();
          end
          chk("n3 in_ready after last", s3_ready, 0);
          chk("n3 busy after last", s3_busy, 1);
          for (int k = 0; k < 20 && !s3_done; k++) tick();
          s3_valid = 1'b0;
          chk("n3 done", s3_done, 1);
          chk("n3 sample_cnt", s3_scnt, 3);
          chk("n3 err_cnt", s3_ecnt, (r == 0) ? 1 : 3);
          chk("n3 sum_abs_err", s3_sum, (r == 0) ? 3 : 1023);
          chk("n3 wce", s3_wce, (r == 0) ? 3 : 511);
        end

        // 1-sample instance: extreme positive and negative errors.
        s1_rst = 1'b0;
`ifdef ADD8U_ERRMON_MSE_EN
        for (int r = 0; r < 3; r++) begin
`else
        for (int r = 0; r < 2; r++) begin
`endif
          s1_start = 1'b1;
          tick();
          s1_start = 1'b0;
          chk("n1 in_ready", s1_ready, 1);
          s1_valid = 1'b1;
          s1_a = (r == 1) ? 8'd255 : 8'd0;
          s1_b = (r == 1) ? 8'd255 : 8'd0;
          s1_o = (r == 0) ? 9'd511 : ((r == 1) ? 9'd0 : 9'd3);
          tick();
          s1_valid = 1'b0;
          chk("n1 in_ready after", s1_ready, 0);
          chk("n1 busy after", s1_busy, 1);
          for (int k = 0; k < 20 && !s1_done; k++) tick();
          chk("n1 done", s1_done, 1);
          chk("n1 sample_cnt", s1_scnt, 1);
          chk("n1 err_cnt", s1_ecnt, 1);
          chk("n1 wce", s1_wce, (r == 0) ? 511 : ((r == 1) ? 510 : 3));
          chk("n1 sum_abs_err", s1_sum, (r == 0) ? 511 : ((r == 1) ? 510 : 3));
`ifdef ADD8U_ERRMON_MSE_EN
          if (r == 2) chk("n1 sum_sq_err", s1_sq, 9);
`endif
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
